// File: rtl/layer2_argmax_readout_pkg.sv
// Shared definitions for the Layer 2 logit readout: state encoding, class tag
// and the logit geometry defaults shared with Layer 2.
package layer2_argmax_readout_pkg;

   localparam int unsigned NUM_OUT_DEF = 10;
   localparam int unsigned LOGIT_W_DEF = 6;
   localparam int unsigned ADDR_W_DEF  = 4;

   localparam logic [3:0] CLASS_TAG = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_EMIT = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/layer2_argmax_readout_argmax_tracker.sv
// Running signed maximum and its index; strict-greater update keeps the lowest
// index on ties. The _c outputs include the sample presented this cycle.
module layer2_argmax_readout_argmax_tracker #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned IDX_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     init_i,
   input  logic                     upd_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic        [IDX_W-1:0]  idx_i,
   output logic signed [DATA_W-1:0] max_c,
   output logic        [IDX_W-1:0]  idx_c
);

   logic signed [DATA_W-1:0] max_q;
   logic        [IDX_W-1:0]  idx_q;

   always_comb begin
      max_c = max_q;
      idx_c = idx_q;
      if (init_i) begin
         max_c = data_i;
         idx_c = idx_i;
      end else if (upd_i && (data_i > max_q)) begin
         max_c = data_i;
         idx_c = idx_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_q <= '0;
         idx_q <= '0;
      end else begin
         max_q <= max_c;
         idx_q <= idx_c;
      end
   end

endmodule

// File: rtl/layer2_argmax_readout.sv
// Layer 2 logit readout: snapshots all logits on a done rise, reports the argmax
// and streams the snapshot plus a class byte over a valid/ready byte port.
module layer2_argmax_readout
   import layer2_argmax_readout_pkg::*;
#(
   parameter int unsigned NUM_OUT = NUM_OUT_DEF,
   parameter int unsigned LOGIT_W = LOGIT_W_DEF,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned EMIT_EN = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      l2_done,
   output logic        [ADDR_W-1:0]  l2_read_addr,
   input  logic signed [LOGIT_W-1:0] l2_read_data,
   output logic                      busy,
   output logic                      result_valid,
   output logic        [ADDR_W-1:0]  class_idx,
   output logic signed [LOGIT_W-1:0] max_logit,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic        [7:0]         out_data
);

   localparam int unsigned BEAT_W = $clog2(NUM_OUT + 1);

   state_e                    state_q, state_d;
   logic                      done_q;
   logic        [ADDR_W-1:0]  addr_q, addr_d;
   logic                      busy_q, busy_d;
   logic                      rv_q, rv_d;
   logic        [ADDR_W-1:0]  cls_q, cls_d;
   logic signed [LOGIT_W-1:0] max_q, max_d;
   logic                      ov_q, ov_d;
   logic        [7:0]         od_q, od_d;
   logic        [BEAT_W-1:0]  beat_q, beat_d;
   logic        [LOGIT_W-1:0] logit_buf_q [NUM_OUT];

   logic                      rise_c, scan_c, last_c;
   logic signed [LOGIT_W-1:0] trk_max_c;
   logic        [ADDR_W-1:0]  trk_idx_c;

   function automatic logic [7:0] sext8(input logic [LOGIT_W-1:0] v);
      return 8'($signed(v));
   endfunction

   assign rise_c = l2_done & ~done_q;
   assign scan_c = (state_q == ST_SCAN);
   assign last_c = (addr_q == ADDR_W'(NUM_OUT - 1));

   layer2_argmax_readout_argmax_tracker #(
      .DATA_W (LOGIT_W),
      .IDX_W  (ADDR_W)
   ) u_tracker (
      .clk    (clk),
      .rst_n  (rst_n),
      .init_i (scan_c && (addr_q == '0)),
      .upd_i  (scan_c),
      .data_i (l2_read_data),
      .idx_i  (addr_q),
      .max_c  (trk_max_c),
      .idx_c  (trk_idx_c)
   );

   // Next-state and output-register logic
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      rv_d    = rv_q;
      cls_d   = cls_q;
      max_d   = max_q;
      ov_d    = ov_q;
      od_d    = od_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (rise_c) begin
               state_d = ST_SCAN;
               addr_d  = '0;
               rv_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_SCAN: begin
            if (last_c) begin
               cls_d  = trk_idx_c;
               max_d  = trk_max_c;
               rv_d   = 1'b1;
               addr_d = '0;
               if (EMIT_EN != 0) begin
                  state_d = ST_EMIT;
                  ov_d    = 1'b1;
                  beat_d  = '0;
                  // With a single logit, entry 0 is still being written this cycle
                  od_d    = sext8((NUM_OUT == 1) ? l2_read_data : logit_buf_q[0]);
               end else begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
               end
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         ST_EMIT: begin
            if (ov_q && out_ready) begin
               if (beat_q == BEAT_W'(NUM_OUT)) begin
                  state_d = ST_DONE;
                  ov_d    = 1'b0;
                  busy_d  = 1'b0;
                  od_d    = '0;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
                  if (beat_q == BEAT_W'(NUM_OUT - 1)) begin
                     od_d = 8'({CLASS_TAG, cls_q});
                  end else begin
                     od_d = sext8(logit_buf_q[beat_q + BEAT_W'(1)]);
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         done_q  <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         cls_q   <= '0;
         max_q   <= '0;
         ov_q    <= 1'b0;
         od_q    <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= l2_done;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         rv_q    <= rv_d;
         cls_q   <= cls_d;
         max_q   <= max_d;
         ov_q    <= ov_d;
         od_q    <= od_d;
         beat_q  <= beat_d;
      end
   end

   // Snapshot buffer; contents are don't-care outside a completed scan
   always_ff @(posedge clk) begin
      if (scan_c) begin
         logit_buf_q[addr_q] <= l2_read_data;
      end
   end

   assign l2_read_addr = addr_q;
   assign busy         = busy_q;
   assign result_valid = rv_q;
   assign class_idx    = cls_q;
   assign max_logit    = max_q;
   assign out_valid    = ov_q;
   assign out_data     = od_q;

endmodule

// File: tb/tb_layer2_argmax_readout.sv
// Self-checking bench for layer2_argmax_readout: an argmax/byte-queue model of the
// snapshot is compared against the DUT every cycle, plus directed literal checks.
module tb_layer2_argmax_readout;

   localparam int N = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, l2_done, l2_done1, out_ready, rdy_rand;
   logic        [3:0] addr0, addr1, cls0, cls1;
   logic signed [5:0] rd0, rd1, max0, max1;
   logic              busy0, busy1, rv0, rv1, ov0, ov1;
   logic        [7:0] od0, od1;
   logic signed [5:0] mem [N];

   assign rd0 = mem[addr0];
   assign rd1 = mem[addr1];

   layer2_argmax_readout #(.NUM_OUT(10), .LOGIT_W(6), .ADDR_W(4), .EMIT_EN(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .l2_done(l2_done), .l2_read_addr(addr0),
      .l2_read_data(rd0), .busy(busy0), .result_valid(rv0), .class_idx(cls0),
      .max_logit(max0), .out_valid(ov0), .out_ready(out_ready), .out_data(od0));

   layer2_argmax_readout #(.NUM_OUT(10), .LOGIT_W(6), .ADDR_W(4), .EMIT_EN(0)) u_dut_noemit (
      .clk(clk), .rst_n(rst_n), .l2_done(l2_done1), .l2_read_addr(addr1),
      .l2_read_data(rd1), .busy(busy1), .result_valid(rv1), .class_idx(cls1),
      .max_logit(max1), .out_valid(ov1), .out_ready(1'b1), .out_data(od1));

   int         errors = 0;
   int         checks = 0;
   int         exp_cls, exp_max, beats, lat;
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   int         vec [N];
   logic [7:0] lit1 [11];
   logic       prev_stall, prev_rv1, prev_busy1;
   logic [7:0] prev_data;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] sx8(input logic signed [5:0] v);
      int t;
      t = v;
      return t[7:0];
   endfunction

   function automatic int ref_argmax();
      int k;
      k = 0;
      for (int i = 1; i < N; i++) if (mem[i] > mem[k]) k = i;
      return k;
   endfunction

   task automatic model_snapshot();
      exp_cls = ref_argmax();
      exp_max = mem[exp_cls];
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_q.push_back(sx8(mem[i]));
      exp_q.push_back(8'hA0 | 8'(exp_cls));
   endtask

   task automatic load();
      for (int i = 0; i < N; i++) mem[i] = 6'(vec[i]);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_addr"}, addr0, 0);   chk({tag, "_busy"}, busy0, 0);
      chk({tag, "_rv"}, rv0, 0);       chk({tag, "_cls"}, cls0, 0);
      chk({tag, "_max"}, max0, 0);     chk({tag, "_ovalid"}, ov0, 0);
      chk({tag, "_odata"}, od0, 0);    chk({tag, "_busy1"}, busy1, 0);
      chk({tag, "_rv1"}, rv1, 0);      chk({tag, "_ovalid1"}, ov1, 0);
   endtask

   // Trigger edge is the next posedge; counts edges until result_valid
   task automatic run_scan(output int l);
      @(posedge clk); #1;
      model_snapshot();
      chk("scan_start_busy", busy0, 1);
      chk("scan_start_rv_low", rv0, 0);
      l = 1;
      while (!rv0 && l < 60) begin
         @(posedge clk); #1;
         l++;
      end
   endtask

   task automatic launch(output int l);
      if (l2_done) begin
         @(negedge clk);
         l2_done = 1'b0;
      end
      @(negedge clk);
      load();
      l2_done = 1'b1;
      run_scan(l);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, busy0, 0);
      chk({name, "_queue_empty"}, exp_q.size(), 0);
   endtask

   // Per-cycle compare against the model, away from the active edge
   initial begin
      prev_stall = 1'b0; prev_rv1 = 1'b0; prev_busy1 = 1'b0; prev_data = '0;
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin
            prev_stall = 1'b0; prev_rv1 = 1'b0; prev_busy1 = 1'b0;
         end else begin
            if (rv0) begin
               chk("class_idx", cls0, exp_cls);
               chk("max_logit", max0, exp_max);
            end
            if (ov0) begin
               chk("busy_in_emit", busy0, 1);
               if (prev_stall) chk("stall_stable", od0, prev_data);
               chk("beat_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  chk("out_data", od0, exp_q[0]);
                  if (out_ready) begin
                     got_q.push_back(od0);
                     void'(exp_q.pop_front());
                     beats++;
                  end
               end
            end
            prev_stall = ov0 & ~out_ready;
            prev_data  = od0;
            chk("noemit_out_valid", ov1, 0);
            if (rv1 && !prev_rv1) begin
               chk("noemit_busy_fall", busy1, 0);
               chk("noemit_busy_before", prev_busy1, 1);
            end
            prev_rv1   = rv1;
            prev_busy1 = busy1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; l2_done = 1'b0; l2_done1 = 1'b0; out_ready = 1'b1; rdy_rand = 1'b0;
      beats = 0; exp_cls = 0; exp_max = 0;
      for (int i = 0; i < N; i++) mem[i] = '0;
      lit1 = '{8'hFD, 8'h05, 8'h00, 8'h1F, 8'hE0, 8'h07, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hA3};
      #1;
      chk_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic scan and stream
      vec = '{-3, 5, 0, 31, -32, 7, 2, 1, 0, -1};
      got_q.delete();
      launch(lat);
      chk("t1_latency", lat, 11);
      chk("t1_class", cls0, 3);
      chk("t1_max", max0, 31);
      wait_idle("t1");
      chk("t1_nbeats", got_q.size(), 11);
      for (int i = 0; i < 11; i++) if (i < got_q.size()) chk("t1_byte", got_q[i], lit1[i]);

      // Ties and all-minimum
      vec = '{4, 9, 9, 0, 0, 0, 0, 0, 0, 0};
      launch(lat);
      chk("t2_tie_class", cls0, 1);
      chk("t2_tie_max", max0, 9);
      wait_idle("t2a");
      vec = '{-32, -32, -32, -32, -32, -32, -32, -32, -32, -32};
      launch(lat);
      chk("t2_min_class", cls0, 0);
      chk("t2_min_max", max0, -32);
      wait_idle("t2b");

      // Random backpressure
      vec = '{1, -2, 3, -4, 5, -6, 7, -8, 9, -10};
      got_q.delete();
      rdy_rand = 1'b1;
      launch(lat);
      chk("t3_class", cls0, 8);
      wait_idle("t3");
      rdy_rand = 1'b0;
      out_ready = 1'b1;
      chk("t3_nbeats", got_q.size(), 11);
      if (got_q.size() == 11) begin
         chk("t3_first", got_q[0], 8'h01);
         chk("t3_tag", got_q[10], 8'hA8);
      end

      // Rise during EMIT ignored; rise in DONE rescans
      @(negedge clk);
      out_ready = 1'b0;
      vec = '{0, 1, 2, 3, 4, 5, 6, 7, 8, -9};
      launch(lat);
      repeat (3) @(negedge clk);
      l2_done = 1'b0;
      repeat (2) @(negedge clk);
      vec = '{20, 3, 3, 3, 3, 3, 3, 3, 3, 3};
      load();
      l2_done = 1'b1;
      repeat (4) @(negedge clk);
      chk("t4_still_busy", busy0, 1);
      chk("t4_no_rescan", addr0, 0);
      chk("t4_rv_held", rv0, 1);
      chk("t4_old_class", cls0, 8);
      got_q.delete();
      out_ready = 1'b1;
      wait_idle("t4a");
      chk("t4_nbeats", got_q.size(), 11);
      if (got_q.size() == 11) begin
         chk("t4_old_last", got_q[9], 8'hF7);
         chk("t4_old_tag", got_q[10], 8'hA8);
      end
      launch(lat);
      chk("t4_rescan_latency", lat, 11);
      chk("t4_new_class", cls0, 0);
      chk("t4_new_max", max0, 20);
      wait_idle("t4b");

      // Reset mid-SCAN with l2_done held high
      vec = '{2, 2, 6, 1, 1, 1, 1, 0, 0, 0};
      @(negedge clk);
      l2_done = 1'b0;
      @(negedge clk);
      load();
      l2_done = 1'b1;
      lat = 0;
      while (addr0 != 4'd5 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("t5_reached_addr5", addr0, 5);
      rst_n = 1'b0;
      #1;
      chk_zero("t5_scan_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_scan(lat);
      chk("t5_scan_relaunch_latency", lat, 11);
      chk("t5_scan_class", cls0, 2);
      wait_idle("t5a");

      // Reset mid-EMIT
      vec = '{-1, -2, -3, -4, 10, -6, -7, -8, -9, -10};
      beats = 0;
      launch(lat);
      lat = 0;
      while (beats < 3 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      @(posedge clk); #1;
      chk("t5_emit_active", ov0, 1);
      rst_n = 1'b0;
      #1;
      chk_zero("t5_emit_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_scan(lat);
      chk("t5_emit_relaunch_latency", lat, 11);
      chk("t5_emit_class", cls0, 4);
      wait_idle("t5b");

      // EMIT disabled instance
      vec = '{-5, -5, -1, -7, 3, 3, -2, 0, 1, 2};
      @(negedge clk);
      load();
      l2_done1 = 1'b1;
      lat = 0;
      while (!rv1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("t6_latency", lat, 11);
      chk("t6_class", cls1, ref_argmax());
      chk("t6_class_lit", cls1, 4);
      chk("t6_max", max1, 3);
      chk("t6_busy", busy1, 0);
      repeat (5) @(negedge clk);
      chk("t6_rv_held", rv1, 1);
      l2_done1 = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
